convolution_procesor_rom_reader: RTL
====================================

// Module: convolution_procesor_rom_reader
// PURPOSE
// - Streams a contiguous sample window out of convolution_procesor_simpleROM (sync ROM, 1-cycle read latency) to the MAC datapath.
// - Drives the ROM address, absorbs its read latency and presents the samples as a valid/ready stream with full backpressure.
// - One instance per operand ROM (memX, memY); the core controller starts each instance.
// PARAMETERS
// - DATA_WIDTH  8  sample width; must match the ROM DATA_WIDTH
// - ADDR_WIDTH  4  ROM address width; the ROM depth is 2**ADDR_WIDTH
// PORTS
// - clk          in   1             rising-edge clock; shared with the ROM
// - rst_n        in   1             asynchronous active-low reset
// - start_i      in   1             1-cycle request to begin a window; sampled only in IDLE
// - base_addr_i  in   ADDR_WIDTH    first ROM address of the window; captured on start
// - length_i     in   ADDR_WIDTH+1  number of samples, 0..2**ADDR_WIDTH; captured on start
// - busy_o       out  1             high from the cycle after an accepted start until done_o
// - done_o       out  1             1-cycle pulse after the last beat is accepted
// - rom_addr_o   out  ADDR_WIDTH    to ROM read_addr_i
// - rom_data_i   in   DATA_WIDTH    from ROM read_data_o; valid 1 cycle after the address is issued
// - data_o       out  DATA_WIDTH    stream data
// - valid_o      out  1             stream valid
// - last_o       out  1             qualifies the final beat of the window
// - ready_i      in   1             stream ready from the consumer
// BEHAVIOUR
// - Reset values: busy_o=0, done_o=0, valid_o=0, last_o=0, data_o=0, rom_addr_o=0; FSM=IDLE, FIFO empty, no read in flight.
// - FSM states: IDLE, RUN, DRAIN, DONE.
//   - IDLE->RUN on start_i with length_i!=0. Captures base and length into addr_q and remain_q.
//   - IDLE->DONE on start_i with length_i==0. No ROM read and no beat; done_o pulses one cycle later.
//   - RUN->DRAIN when the last read is issued (remain_q reaches 0).
//   - DRAIN->DONE when the beat with last_o is accepted (valid_o & ready_i).
//   - DONE->IDLE unconditionally. done_o=1 only in DONE.
// - start_i is ignored outside IDLE. Base and length inputs are not re-sampled mid-window.
// - Read issue: in RUN, a read is issued in any cycle where fifo_count + inflight + issue_now <= 2 after the pop that cycle.
//   - Issue rule: issue when (fifo_count - pop + inflight) < 2.
//   - On issue, rom_addr_o = addr_q; addr_q increments and remain_q decrements.
//   - inflight is a 1-bit flag set on issue; the data is pushed into the FIFO the next cycle.
// - Address wrap: addr_q increments modulo 2**ADDR_WIDTH (e.g. 4'hF -> 4'h0). A window may straddle the top of the ROM.
// - Output: data_o, valid_o and last_o come from the head of a 2-entry FIFO. No combinational path from ready_i to valid_o or data_o.
//   - Each entry stores {last, data}. last is set on the entry whose read was issued with remain_q==1.
// - Simultaneous push and pop on a full FIFO is legal; the issue rule guarantees no overflow.
// - Throughput: 1 beat/cycle with ready_i held high. First valid_o 2 cycles after the start_i edge (IDLE->RUN, then ROM latency).
// - Backpressure: data_o and last_o are stable while valid_o & !ready_i. At most 2 reads are outstanding.
// - Reset mid-operation: all state returns to reset values immediately. In-flight ROM data is discarded; no done_o is produced.
// - Arithmetic: remain_q is ADDR_WIDTH+1 bits, so a full-depth window is legal. A length_i above 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.
// STRUCTURE
// - convolution_procesor_pkg holds:
//   - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rom_rd_state_e
//   - localparam FIFO_DEPTH = 2
// - One sub-module: convolution_procesor_fifo2. Parameterised width, async active-low reset, push/pop/count/head.
// - FSM, address counter and issue logic live in this module.
// TESTING
// - Test ROM: convolution_procesor_simpleROM with data[a] = a + 8'h10.
// 1. Reset, then start base=0 len=16 with ready_i=1 -> 16 beats 8'h10..8'h1F on consecutive cycles, last_o on 8'h1F, done_o pulse once.
// 2. base=4'hE len=4 -> beats 8'h1E, 8'h1F, 8'h10, 8'h11 (wrap); last_o on 8'h11.
// 3. len=0 -> no valid_o, no ROM address change, done_o one cycle after start, busy_o one cycle.
// 4. base=2 len=5, ready_i random 50% -> exact sequence 8'h12..8'h16, no drop or duplicate. data_o stable while stalled; outstanding reads never exceed 2.
// 5. Second start_i pulsed while busy -> ignored; the original window completes unchanged.
// 6. rst_n asserted after the 3rd beat of base=0 len=8 -> outputs 0 asynchronously; a new start base=8 len=2 yields 8'h18, 8'h19 only.

Source files
------------

// File: rtl/convolution_procesor_pkg.sv
// Shared types and sizing for the convolution processor ROM reader.
package convolution_procesor_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rom_rd_state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/convolution_procesor_fifo2.sv
// Two-entry FIFO that buffers ROM read data so that backpressure never drops samples.
module convolution_procesor_fifo2
  import convolution_procesor_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  // A push into a full FIFO is only issued together with a pop; the slot written is the one being vacated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/convolution_procesor_rom_reader.sv
// Streams a contiguous window out of a 1-cycle-latency sync ROM as a valid/ready stream.
module convolution_procesor_rom_reader
  import convolution_procesor_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i
);

  localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  rom_rd_state_e         state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  inflight;
  logic                  inflight_last;
  logic [ADDR_WIDTH:0]   len_clamped;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [2:0]            occupancy;
  logic                  pop;
  logic                  issue;

  assign len_clamped = (length_i > MAX_LEN) ? MAX_LEN : length_i;

  assign valid_o          = (fifo_count != 2'd0);
  assign {last_o, data_o} = fifo_head;
  assign pop              = valid_o & ready_i;
  assign rom_addr_o       = addr_q;

  // Count the FIFO after this cycle's pop plus the read still in the ROM pipe; never exceed two.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && (remain_q != '0) && (occupancy < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (len_clamped == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && (remain_q == LEN_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && last_o) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address wraps naturally at the top of the ROM; remain_q has one extra bit for a full-depth window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      remain_q      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remain_q == LEN_ONE);
      if ((state == IDLE) && start_i && (len_clamped != '0)) begin
        addr_q   <= base_addr_i;
        remain_q <= len_clamped;
      end else if (issue) begin
        addr_q   <= addr_q + ADDR_ONE;
        remain_q <= remain_q - LEN_ONE;
      end
    end
  end

  convolution_procesor_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, rom_data_i}),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule
